// File: rtl/fetch_pc_select_pkg.sv
// Shared widths, reset PC and the next-PC select encoding for the fetch stage.
// The hazard unit and bench reuse next_sel_e to interpret the fetch decision.
package fetch_pc_select_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 16;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [2:0] {
    SEL_BEQ  = 3'd0,
    SEL_JLR  = 3'd1,
    SEL_JAL  = 3'd2,
    SEL_HOLD = 3'd3,
    SEL_PRED = 3'd4,
    SEL_SEQ  = 3'd5
  } next_sel_e;

endpackage

// File: rtl/fetch_pc_select_if.sv
// Fetch-stage bundle: redirects and predictor in, PC, IF/ID and flush out.
// slave is the fetch unit's view; master is the surrounding pipeline's view.
interface fetch_pc_select_if
  import fetch_pc_select_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
);

  logic                 stall;
  logic                 pred_taken;
  logic [PC_W-1:0]      pred_target;
  logic                 beq_redirect;
  logic [PC_W-1:0]      beq_redirect_pc;
  logic                 jlr_redirect;
  logic [PC_W-1:0]      jlr_target;
  logic                 jal_redirect;
  logic [PC_W-1:0]      jal_target;
  logic [INSTR_W-1:0]   imem_rdata;

  logic [PC_W-1:0]      curr_pc;
  logic [PC_W-1:0]      IF_ID_pc;
  logic [PC_W-1:0]      IF_ID_pc_p1;
  logic [INSTR_W-1:0]   IF_ID_instr;
  logic                 IF_ID_valid;
  logic                 IF_ID_pred_taken;
  logic                 flush_id_rr;
  logic [CNT_WIDTH-1:0] redirect_cnt;

  modport master (
    output stall, pred_taken, pred_target, beq_redirect, beq_redirect_pc,
           jlr_redirect, jlr_target, jal_redirect, jal_target, imem_rdata,
    input  curr_pc, IF_ID_pc, IF_ID_pc_p1, IF_ID_instr, IF_ID_valid,
           IF_ID_pred_taken, flush_id_rr, redirect_cnt
  );

  modport slave (
    input  stall, pred_taken, pred_target, beq_redirect, beq_redirect_pc,
           jlr_redirect, jlr_target, jal_redirect, jal_target, imem_rdata,
    output curr_pc, IF_ID_pc, IF_ID_pc_p1, IF_ID_instr, IF_ID_valid,
           IF_ID_pred_taken, flush_id_rr, redirect_cnt
  );

endinterface

// File: rtl/fetch_pc_select_next_pc_mux.sv
// Combinational next-PC priority encoder and mux.
// Order: BEQ fix, JLR, JAL, stall hold, predicted taken, sequential.
module fetch_pc_select_next_pc_mux
  import fetch_pc_select_pkg::*;
(
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_beq,
  input  logic [PC_W-1:0] i_beq_pc,
  input  logic            i_jlr,
  input  logic [PC_W-1:0] i_jlr_pc,
  input  logic            i_jal,
  input  logic [PC_W-1:0] i_jal_pc,
  input  logic            i_stall,
  input  logic            i_pred,
  input  logic [PC_W-1:0] i_pred_pc,
  output next_sel_e       o_sel,
  output logic [PC_W-1:0] o_next_pc
);

  always_comb begin
    o_sel = SEL_SEQ;
    if (i_beq) begin
      o_sel = SEL_BEQ;
    end else if (i_jlr) begin
      o_sel = SEL_JLR;
    end else if (i_jal) begin
      o_sel = SEL_JAL;
    end else if (i_stall) begin
      o_sel = SEL_HOLD;
    end else if (i_pred) begin
      o_sel = SEL_PRED;
    end
  end

  always_comb begin
    o_next_pc = i_pc + 16'd1;
    unique case (o_sel)
      SEL_BEQ:  o_next_pc = i_beq_pc;
      SEL_JLR:  o_next_pc = i_jlr_pc;
      SEL_JAL:  o_next_pc = i_jal_pc;
      SEL_HOLD: o_next_pc = i_pc;
      SEL_PRED: o_next_pc = i_pred_pc;
      default:  o_next_pc = i_pc + 16'd1;
    endcase
  end

endmodule

// File: rtl/fetch_pc_select.sv
// IF stage: PC register, IF/ID pipeline register, wrong-path flush and
// a saturating count of EX-stage redirects.
module fetch_pc_select
  import fetch_pc_select_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned     CNT_WIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  fetch_pc_select_if.slave bus
);

  logic [PC_W-1:0]      r_pc;
  logic [PC_W-1:0]      r_if_pc;
  logic [PC_W-1:0]      r_if_pc_p1;
  logic [INSTR_W-1:0]   r_if_instr;
  logic                 r_if_valid;
  logic                 r_if_pred;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_ex_redir;
  next_sel_e            w_sel;
  logic [PC_W-1:0]      w_next_pc;

  assign w_ex_redir = bus.beq_redirect | bus.jlr_redirect;

  fetch_pc_select_next_pc_mux u_mux (
    .i_pc      (r_pc),
    .i_beq     (bus.beq_redirect),
    .i_beq_pc  (bus.beq_redirect_pc),
    .i_jlr     (bus.jlr_redirect),
    .i_jlr_pc  (bus.jlr_target),
    .i_jal     (bus.jal_redirect),
    .i_jal_pc  (bus.jal_target),
    .i_stall   (bus.stall),
    .i_pred    (bus.pred_taken),
    .i_pred_pc (bus.pred_target),
    .o_sel     (w_sel),
    .o_next_pc (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_if_pc    <= '0;
      r_if_pc_p1 <= '0;
      r_if_instr <= '0;
      r_if_valid <= 1'b0;
      r_if_pred  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_pc <= w_next_pc;
      // Redirects kill the IF-stage instruction; a stall freezes IF/ID.
      unique case (w_sel)
        SEL_BEQ, SEL_JLR, SEL_JAL: r_if_valid <= 1'b0;
        SEL_HOLD: ;
        default: begin
          r_if_pc    <= r_pc;
          r_if_pc_p1 <= r_pc + 16'd1;
          r_if_instr <= bus.imem_rdata;
          r_if_valid <= 1'b1;
          r_if_pred  <= bus.pred_taken;
        end
      endcase
      if (w_ex_redir && (r_cnt != {CNT_WIDTH{1'b1}})) begin
        r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.curr_pc          = r_pc;
  assign bus.IF_ID_pc         = r_if_pc;
  assign bus.IF_ID_pc_p1      = r_if_pc_p1;
  assign bus.IF_ID_instr      = r_if_instr;
  assign bus.IF_ID_valid      = r_if_valid;
  assign bus.IF_ID_pred_taken = r_if_pred;
  assign bus.flush_id_rr      = w_ex_redir;
  assign bus.redirect_cnt     = r_cnt;

endmodule

// File: tb/tb_fetch_pc_select.sv
// Self-checking bench for fetch_pc_select: directed scenarios plus a random
// run against a behavioural model of the fetch stage.
module tb_fetch_pc_select;
  import fetch_pc_select_pkg::*;

  localparam logic [15:0] IMEM_KEY = 16'hA5C3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_pc_select_if #(.CNT_WIDTH(16)) bus ();

  assign bus.imem_rdata = bus.curr_pc ^ IMEM_KEY;

  fetch_pc_select #(.RESET_PC(16'h0000), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Behavioural model state.
  logic [15:0] m_pc, m_ifpc, m_ifpc1, m_instr, m_cnt;
  logic        m_valid, m_pt;

  task automatic idle_inputs();
    bus.stall = 0; bus.pred_taken = 0; bus.pred_target = 0;
    bus.beq_redirect = 0; bus.beq_redirect_pc = 0;
    bus.jlr_redirect = 0; bus.jlr_target = 0;
    bus.jal_redirect = 0; bus.jal_target = 0;
  endtask

  // One clock: model applies the fetch rules to the inputs present at the edge.
  task automatic step();
    logic ex;
    @(posedge clk);
    ex = bus.beq_redirect | bus.jlr_redirect;
    if (rst) begin
      m_pc = 16'h0000; m_ifpc = 0; m_ifpc1 = 0; m_instr = 0;
      m_valid = 0; m_pt = 0; m_cnt = 0;
    end else begin
      if (ex && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      if (ex || bus.jal_redirect) m_valid = 0;
      else if (!bus.stall) begin
        m_ifpc = m_pc; m_ifpc1 = m_pc + 1; m_instr = m_pc ^ IMEM_KEY;
        m_valid = 1; m_pt = bus.pred_taken;
      end
      if (bus.beq_redirect)      m_pc = bus.beq_redirect_pc;
      else if (bus.jlr_redirect) m_pc = bus.jlr_target;
      else if (bus.jal_redirect) m_pc = bus.jal_target;
      else if (bus.stall)        m_pc = m_pc;
      else if (bus.pred_taken)   m_pc = bus.pred_target;
      else                       m_pc = m_pc + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    bus.pred_taken = 1; bus.pred_target = 16'h7777;
    step(); step();
    n_vec++;
    if (bus.curr_pc !== 16'h0000) begin
      n_err++; $display("FAIL reset_pc got %h want 0000", bus.curr_pc);
    end
    n_vec++;
    if (bus.IF_ID_valid !== 1'b0 || bus.IF_ID_pc !== 16'h0 || bus.IF_ID_instr !== 16'h0
        || bus.IF_ID_pc_p1 !== 16'h0 || bus.IF_ID_pred_taken !== 1'b0) begin
      n_err++; $display("FAIL reset_ifid got v=%b pc=%h instr=%h want zeros",
                        bus.IF_ID_valid, bus.IF_ID_pc, bus.IF_ID_instr);
    end
    n_vec++;
    if (bus.redirect_cnt !== 16'h0) begin
      n_err++; $display("FAIL reset_cnt got %h want 0000", bus.redirect_cnt);
    end
    idle_inputs();
    rst = 0;
    #1;
  endtask

  task automatic test_seq();
    n_vec++;
    if (bus.curr_pc !== 16'h0000 || bus.IF_ID_valid !== 1'b0) begin
      n_err++; $display("FAIL seq_first got pc=%h v=%b want 0000/0", bus.curr_pc,
                        bus.IF_ID_valid);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_vec++;
      if (bus.curr_pc !== 16'(i) || bus.IF_ID_valid !== 1'b1 || bus.IF_ID_pc !== 16'(i - 1)
          || bus.IF_ID_instr !== (16'(i - 1) ^ IMEM_KEY)) begin
        n_err++; $display("FAIL seq_%0d got pc=%h v=%b ifpc=%h want %h/1/%h", i,
                          bus.curr_pc, bus.IF_ID_valid, bus.IF_ID_pc, 16'(i), 16'(i - 1));
      end
    end
  endtask

  task automatic test_pred();
    step(); step();
    bus.pred_taken = 1; bus.pred_target = 16'h0020;
    #1;
    n_vec++;
    if (bus.curr_pc !== 16'h0005 || bus.flush_id_rr !== 1'b0) begin
      n_err++; $display("FAIL pred_pre got pc=%h flush=%b want 0005/0", bus.curr_pc,
                        bus.flush_id_rr);
    end
    step();
    idle_inputs();
    n_vec++;
    if (bus.curr_pc !== 16'h0020 || bus.IF_ID_pc !== 16'h0005
        || bus.IF_ID_pred_taken !== 1'b1 || bus.IF_ID_pc_p1 !== 16'h0006) begin
      n_err++; $display("FAIL pred_taken got pc=%h ifpc=%h pt=%b want 0020/0005/1",
                        bus.curr_pc, bus.IF_ID_pc, bus.IF_ID_pred_taken);
    end
  endtask

  task automatic test_beq();
    bus.beq_redirect = 1; bus.beq_redirect_pc = 16'h0006;
    bus.stall = 1; bus.pred_taken = 1; bus.pred_target = 16'h0099;
    #1;
    n_vec++;
    if (bus.flush_id_rr !== 1'b1) begin
      n_err++; $display("FAIL beq_flush got %b want 1", bus.flush_id_rr);
    end
    step();
    idle_inputs();
    #1;
    n_vec++;
    if (bus.curr_pc !== 16'h0006 || bus.IF_ID_valid !== 1'b0 || bus.redirect_cnt !== 16'd1
        || bus.flush_id_rr !== 1'b0) begin
      n_err++; $display("FAIL beq_redirect got pc=%h v=%b cnt=%h want 0006/0/0001",
                        bus.curr_pc, bus.IF_ID_valid, bus.redirect_cnt);
    end
  endtask

  task automatic test_jal();
    step();
    bus.jal_redirect = 1; bus.jal_target = 16'h0040;
    #1;
    n_vec++;
    if (bus.IF_ID_valid !== 1'b1 || bus.IF_ID_pc !== 16'h0006 || bus.flush_id_rr !== 1'b0) begin
      n_err++; $display("FAIL jal_pre got v=%b ifpc=%h flush=%b want 1/0006/0",
                        bus.IF_ID_valid, bus.IF_ID_pc, bus.flush_id_rr);
    end
    step();
    idle_inputs();
    n_vec++;
    if (bus.curr_pc !== 16'h0040 || bus.IF_ID_valid !== 1'b0 || bus.redirect_cnt !== 16'd1) begin
      n_err++; $display("FAIL jal_redirect got pc=%h v=%b cnt=%h want 0040/0/0001",
                        bus.curr_pc, bus.IF_ID_valid, bus.redirect_cnt);
    end
  endtask

  task automatic test_stall();
    bus.pred_taken = 1; bus.pred_target = 16'h0010;
    step();
    idle_inputs();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (bus.curr_pc !== 16'h0010 || bus.IF_ID_pc !== 16'h0040 || bus.IF_ID_valid !== 1'b1) begin
        n_err++; $display("FAIL stall_hold_%0d got pc=%h ifpc=%h want 0010/0040", i,
                          bus.curr_pc, bus.IF_ID_pc);
      end
    end
    bus.stall = 0;
    step();
    n_vec++;
    if (bus.curr_pc !== 16'h0011 || bus.IF_ID_pc !== 16'h0010
        || bus.IF_ID_instr !== (16'h0010 ^ IMEM_KEY)) begin
      n_err++; $display("FAIL stall_release got pc=%h ifpc=%h want 0011/0010", bus.curr_pc,
                        bus.IF_ID_pc);
    end
  endtask

  task automatic test_wrap_reset();
    bus.pred_taken = 1; bus.pred_target = 16'hFFFF;
    step();
    idle_inputs();
    step();
    n_vec++;
    if (bus.curr_pc !== 16'h0000 || bus.IF_ID_pc !== 16'hFFFF || bus.IF_ID_pc_p1 !== 16'h0000) begin
      n_err++; $display("FAIL wrap got pc=%h ifpc=%h p1=%h want 0000/FFFF/0000", bus.curr_pc,
                        bus.IF_ID_pc, bus.IF_ID_pc_p1);
    end
    rst = 1; bus.jlr_redirect = 1; bus.jlr_target = 16'h1234;
    step();
    idle_inputs();
    rst = 0;
    #1;
    n_vec++;
    if (bus.curr_pc !== 16'h0000 || bus.IF_ID_valid !== 1'b0 || bus.IF_ID_pc !== 16'h0
        || bus.IF_ID_instr !== 16'h0 || bus.redirect_cnt !== 16'h0) begin
      n_err++; $display("FAIL mid_reset got pc=%h v=%b cnt=%h want 0000/0/0000", bus.curr_pc,
                        bus.IF_ID_valid, bus.redirect_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      idle_inputs();
      r = $urandom_range(99);
      if (r < 6)       begin bus.beq_redirect = 1; bus.beq_redirect_pc = 16'($urandom); end
      else if (r < 12) begin bus.jlr_redirect = 1; bus.jlr_target = 16'($urandom); end
      else if (r < 20 && m_valid) begin bus.jal_redirect = 1; bus.jal_target = 16'($urandom); end
      if (!bus.jal_redirect) bus.stall = ($urandom_range(4) == 0);
      bus.pred_taken  = ($urandom_range(3) == 0);
      bus.pred_target = 16'($urandom);
      #1;
      n_vec++;
      if (bus.flush_id_rr !== (bus.beq_redirect | bus.jlr_redirect)) begin
        n_err++; $display("FAIL rand_flush_%0d got %b", i, bus.flush_id_rr);
      end
      step();
      n_vec++;
      if (bus.curr_pc !== m_pc || bus.IF_ID_valid !== m_valid || bus.redirect_cnt !== m_cnt
          || (m_valid && (bus.IF_ID_pc !== m_ifpc || bus.IF_ID_pc_p1 !== m_ifpc1
              || bus.IF_ID_instr !== m_instr || bus.IF_ID_pred_taken !== m_pt))) begin
        n_err++;
        $display("FAIL rand_%0d got pc=%h v=%b ifpc=%h cnt=%h want pc=%h v=%b ifpc=%h cnt=%h",
                 i, bus.curr_pc, bus.IF_ID_valid, bus.IF_ID_pc, bus.redirect_cnt,
                 m_pc, m_valid, m_ifpc, m_cnt);
      end
    end
    idle_inputs();
  endtask

  task automatic test_saturate();
    rst = 1;
    step();
    rst = 0;
    bus.beq_redirect = 1; bus.beq_redirect_pc = 16'h0100;
    for (int i = 0; i < 65534; i++) step();
    n_vec++;
    if (bus.redirect_cnt !== 16'hFFFE) begin
      n_err++; $display("FAIL sat_pre got %h want FFFE", bus.redirect_cnt);
    end
    step(); step(); step();
    n_vec++;
    if (bus.redirect_cnt !== 16'hFFFF || bus.redirect_cnt !== m_cnt) begin
      n_err++; $display("FAIL sat_hold got %h want FFFF", bus.redirect_cnt);
    end
    idle_inputs();
  endtask

  initial begin
    m_pc = 0; m_ifpc = 0; m_ifpc1 = 0; m_instr = 0; m_cnt = 0; m_valid = 0; m_pt = 0;
    idle_inputs();
    #1;
    test_reset();
    test_seq();
    test_pred();
    test_beq();
    test_jal();
    test_stall();
    test_wrap_reset();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
